fan_pwm: RTL and testbench

Fan PWM generator, the output-side companion of the tachometer counter. It drives the fan control pin from a CSR-programmed duty cycle. The duty cycle is updated glitch-free at PWM period boundaries, with an optional soft-start ramp. It sits on the shared 5-bit CSR bus and its read data is OR-combined with the other CSR slaves.

---
 rtl/fan_pwm_prescaler.sv | 44 ++++
 rtl/fan_pwm.sv | 133 +++++++++++++
 tb/tb_fan_pwm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fan_pwm_prescaler.sv
// ============================================================================
// fan_pwm_prescaler : divides the ce_pwm strobe by 1/2/4/8 into PWM step ticks
// Revision: 1.0
// ============================================================================
`default_nettype none

module fan_pwm_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_pwm_i,
  input  logic [1:0] div_sel_i,
  input  logic       clr_i,
  output logic       tick_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [2:0] cnt_max;
  logic       at_max;

  assign cnt_max = (3'd1 << div_sel_i) - 3'd1;
  assign at_max  = (cnt_q == cnt_max);
  // A clear in the same clk suppresses the tick so counting restarts cleanly.
  assign tick_o  = ce_pwm_i & at_max & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 3'd0;
    end else if (ce_pwm_i) begin
      cnt_d = at_max ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fan_pwm.sv
// ============================================================================
// fan_pwm : CSR-programmed fan PWM, 128-step period, glitch-free duty updates
// Revision: 1.0
// ============================================================================
`default_nettype none

module fan_pwm #(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter int         RAMP_STEP     = 4,
  parameter logic       DISABLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_pwm,
  output logic       pwm_out
);

  localparam logic [4:0] ADDR_CTRL  = BASE_ADDR;
  localparam logic [4:0] ADDR_DUTY  = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_STAT  = BASE_ADDR + 5'd2;
  localparam logic [7:0] DUTY_MAX   = 8'd128;
  localparam logic [6:0] STEP_LAST  = 7'd127;
  localparam logic [7:0] CTRL_MASK  = 8'hC3;
  localparam logic [7:0] STEP       = 8'(RAMP_STEP);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] applied_q, applied_d;
  logic [6:0] step_q, step_d;
  logic       pwm_q, pwm_d;

  logic       ctrl_wr, duty_wr, tick, presc_clr;
  logic [7:0] target, ramped;

  assign ctrl_wr   = csr_we && (csr_a == ADDR_CTRL);
  assign duty_wr   = csr_we && (csr_a == ADDR_DUTY);
  assign target    = (duty_q > DUTY_MAX) ? DUTY_MAX : duty_q;
  assign presc_clr = ctrl_wr || (state_q == ST_IDLE);

  fan_pwm_prescaler u_presc (
    .clk       (clk),
    .rst       (rst),
    .ce_pwm_i  (ce_pwm),
    .div_sel_i (ctrl_q[1:0]),
    .clr_i     (presc_clr),
    .tick_o    (tick)
  );

  // Ramp toward the target, landing exactly on it when within one step.
  always_comb begin
    ramped = applied_q;
    if (applied_q < target) begin
      ramped = ((target - applied_q) <= STEP) ? target : applied_q + STEP;
    end else if (applied_q > target) begin
      ramped = ((applied_q - target) <= STEP) ? target : applied_q - STEP;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_wr ? (csr_di & CTRL_MASK) : ctrl_q;
    duty_d    = duty_wr ? csr_di : duty_q;
    applied_d = applied_q;
    step_d    = step_q;
    case (state_q)
      ST_IDLE: begin
        step_d    = 7'd0;
        applied_d = 8'd0;
        if (ctrl_wr && csr_di[7]) begin
          state_d   = ST_RUN;
          applied_d = csr_di[6] ? 8'd0 : target;
        end
      end
      ST_RUN: begin
        if (ctrl_wr && !csr_di[7]) begin
          state_d   = ST_IDLE;
          step_d    = 7'd0;
          applied_d = 8'd0;
        end else if (tick) begin
          step_d = step_q + 7'd1;
          if (step_q == STEP_LAST) begin
            applied_d = ctrl_q[6] ? ramped : target;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pwm_d = ((state_q == ST_RUN) && (state_d == ST_RUN))
          ? ({1'b0, step_q} < applied_q) : DISABLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 8'd0;
      duty_q    <= 8'd0;
      applied_q <= 8'd0;
      step_q    <= 7'd0;
      pwm_q     <= DISABLE_LEVEL;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      duty_q    <= duty_d;
      applied_q <= applied_d;
      step_q    <= step_d;
      pwm_q     <= pwm_d;
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == ADDR_CTRL) csr_do = ctrl_q;
    else if (csr_a == ADDR_DUTY) csr_do = duty_q;
    else if (csr_a == ADDR_STAT) csr_do = applied_q;
  end

  assign pwm_out = pwm_q;

endmodule

`default_nettype wire

// File: tb/tb_fan_pwm.sv
// ============================================================================
// tb_fan_pwm : directed self-checking bench for fan_pwm
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fan_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       ce_pwm;
  logic       pwm_out;

  int total = 0;
  int bad   = 0;
  int ce_period = 1;

  always #5 clk = ~clk;

  fan_pwm #(
    .BASE_ADDR     (5'h0),
    .RAMP_STEP     (4),
    .DISABLE_LEVEL (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .csr_a   (csr_a),
    .csr_di  (csr_di),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .ce_pwm  (ce_pwm),
    .pwm_out (pwm_out)
  );

  initial begin : ce_gen
    int k;
    k = 0;
    ce_pwm = 1'b1;
    forever begin
      @(negedge clk);
      k = (k + 1 >= ce_period) ? 0 : k + 1;
      ce_pwm = (k == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; write lands on the next posedge, returns at the negedge after it.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    check(tag, {24'd0, csr_do}, {24'd0, exp});
  endtask

  task automatic run(input int n, output int hi, output int rises);
    logic prev;
    prev  = pwm_out;
    hi    = 0;
    rises = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (pwm_out && !prev) rises++;
      prev = pwm_out;
    end
  endtask

  initial begin : stim
    int hi, rs, acc;
    int ramp_exp [5] = '{4, 8, 12, 14, 14};
    rst = 1'b1; csr_we = 1'b0; csr_a = 5'd0; csr_di = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 1);
    rst = 1'b0;
    rd_chk("rst_ctrl", 5'd0, 8'd0);
    rd_chk("rst_duty", 5'd1, 8'd0);
    rd_chk("rst_stat", 5'd2, 8'd0);

    // duty 32, ce every clk, div 0
    wr(5'd1, 8'd32);
    wr(5'd0, 8'hBC);
    check("en_first_pwm", pwm_out, 1);
    rd_chk("ctrl_rd_mask", 5'd0, 8'h80);
    run(128, hi, rs);
    check("d32_first_hi", hi, 32);
    run(128, hi, rs);
    check("d32_hi", hi, 32);
    check("d32_rises", rs, 1);
    rd_chk("d32_stat", 5'd2, 8'd32);

    wr(5'd1, 8'd0);
    run(256, hi, rs);
    run(128, hi, rs);
    check("d0_hi", hi, 0);
    rd_chk("d0_stat", 5'd2, 8'd0);

    wr(5'd1, 8'd200);
    run(256, hi, rs);
    run(128, hi, rs);
    check("d200_hi", hi, 128);
    rd_chk("d200_stat", 5'd2, 8'd128);
    rd_chk("d200_duty_raw", 5'd1, 8'd200);
    wr(5'd2, 8'h55);
    rd_chk("stat_ro", 5'd2, 8'd128);
    rd_chk("unowned_3", 5'd3, 8'd0);
    rd_chk("unowned_1f", 5'h1F, 8'd0);

    // soft-start ramp toward 14, then back down to 6
    wr(5'd0, 8'h00);
    wr(5'd1, 8'd14);
    wr(5'd0, 8'hC0);
    rd_chk("ramp_start", 5'd2, 8'd0);
    for (int i = 0; i < 5; i++) begin
      run(128, hi, rs);
      rd_chk($sformatf("ramp_up_%0d", i), 5'd2, 8'(ramp_exp[i]));
    end
    wr(5'd1, 8'd6);
    run(127, hi, rs);
    rd_chk("ramp_dn_0", 5'd2, 8'd10);
    run(128, hi, rs);
    rd_chk("ramp_dn_1", 5'd2, 8'd6);

    // div_sel=2 -> 512-clk period, then ce every 3rd clk -> 1536
    wr(5'd0, 8'h00);
    wr(5'd1, 8'd64);
    wr(5'd0, 8'h82);
    run(1024, hi, rs);
    run(512, hi, rs);
    check("div4_hi", hi, 256);
    check("div4_rises", rs, 1);
    ce_period = 3;
    run(3072, hi, rs);
    run(1536, hi, rs);
    check("div4_ce3_hi", hi, 768);
    check("div4_ce3_rises", rs, 1);
    ce_period = 1;

    // duty write in the period-end clk, and mid-period
    wr(5'd0, 8'h00);
    wr(5'd1, 8'd32);
    wr(5'd0, 8'h80);
    run(127, hi, rs);
    wr(5'd1, 8'd96);
    run(128, hi, rs);
    check("bnd_keep", hi, 32);
    run(128, hi, rs);
    check("bnd_next", hi, 96);
    run(10, hi, rs);
    acc = hi;
    wr(5'd1, 8'd32);
    acc += int'(pwm_out);
    run(117, hi, rs);
    acc += hi;
    check("mid_keep", acc, 96);
    run(128, hi, rs);
    check("mid_next", hi, 32);

    // disable mid-period
    run(50, hi, rs);
    check("pre_dis_low", pwm_out, 0);
    wr(5'd0, 8'h00);
    check("dis_lat", pwm_out, 1);
    rd_chk("dis_stat", 5'd2, 8'd0);
    run(5, hi, rs);
    check("dis_hold", hi, 5);

    // reset while running
    wr(5'd0, 8'h80);
    run(50, hi, rs);
    check("pre_rst_low", pwm_out, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_lat", pwm_out, 1);
    rst = 1'b0;
    rd_chk("rst2_ctrl", 5'd0, 8'd0);
    rd_chk("rst2_duty", 5'd1, 8'd0);
    rd_chk("rst2_stat", 5'd2, 8'd0);
    run(5, hi, rs);
    check("rst2_hold", hi, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
